// File: rtl/cr16_pkg.sv
// Shared CR16 decode definitions: opcode/extension encodings and the
// decoded control-field bundle carried through the decode stage.
package cr16_pkg;

  // Primary opcode groups, instr[15:12]
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  // Extension field values, instr[7:4]
  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] EXT_ASH   = 4'b0110;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1000;
  localparam logic [3:0] EXT_JAL   = 4'b1100;

  // Shift-immediate forms are identified by ext[3:1]; ext[0] is immediate bit 4
  localparam logic [2:0] EXT_LSHI_HI = 3'b000;
  localparam logic [2:0] EXT_ASHI_HI = 3'b001;

  // Everything the decoder produces except the DATA_W-wide immediate
  typedef struct packed {
    logic [7:0] op;
    logic [3:0] r_dest;
    logic [3:0] r_src;
    logic       r_or_i;
    logic       is_branch;
    logic       is_jump;
    logic       is_mem;
    logic       mem_write;
    logic       illegal;
  } dec_ctrl_t;

  localparam int DEC_CTRL_W = $bits(dec_ctrl_t);

endpackage

// File: rtl/decode_comb.sv
// Purely combinational CR16 instruction decoder: raw word -> control fields
// and extended immediate.
module decode_comb
  import cr16_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ZEXT_LOGIC = 1
) (
  input  logic [15:0]       instr,
  output dec_ctrl_t         ctrl,
  output logic [DATA_W-1:0] imm
);

  logic [3:0]        op4;
  logic [3:0]        ext;
  logic [DATA_W-1:0] imm_s8;
  logic [DATA_W-1:0] imm_z8;
  logic [DATA_W-1:0] imm_s5;
  logic [DATA_W-1:0] imm_lui;

  assign op4     = instr[15:12];
  assign ext     = instr[7:4];
  assign imm_s8  = DATA_W'($signed(instr[7:0]));
  assign imm_z8  = DATA_W'(instr[7:0]);
  assign imm_s5  = DATA_W'($signed(instr[4:0]));
  assign imm_lui = DATA_W'($signed({instr[7:0], 8'h00}));

  // Field decode; unrecognised encodings fall back to op={op4,ext} with only illegal set
  always_comb begin
    ctrl    = '0;
    ctrl.op = {op4, ext};
    imm     = '0;
    case (op4)
      OP_RTYPE: begin
        ctrl.r_dest = instr[11:8];
        ctrl.r_src  = instr[3:0];
        ctrl.r_or_i = 1'b1;
      end
      OP_SHIFT: begin
        if (ext == EXT_LSH || ext == EXT_ASH) begin
          ctrl.r_dest = instr[11:8];
          ctrl.r_src  = instr[3:0];
          ctrl.r_or_i = 1'b1;
        end else if (ext[3:1] == EXT_LSHI_HI || ext[3:1] == EXT_ASHI_HI) begin
          ctrl.r_dest = instr[11:8];
          imm         = imm_s5;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OP_MEM: begin
        case (ext)
          EXT_LOAD, EXT_STOR: begin
            ctrl.r_dest    = instr[11:8];
            ctrl.r_src     = instr[3:0];
            ctrl.r_or_i    = 1'b1;
            ctrl.is_mem    = 1'b1;
            ctrl.mem_write = (ext == EXT_STOR);
          end
          EXT_JCOND, EXT_JAL: begin
            ctrl.r_dest  = instr[11:8];
            ctrl.r_src   = instr[3:0];
            ctrl.r_or_i  = 1'b1;
            ctrl.is_jump = 1'b1;
          end
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_BCOND: begin
        ctrl.op        = {op4, instr[11:8]};
        ctrl.is_branch = 1'b1;
        imm            = imm_s8;
      end
      OP_LUI: begin
        ctrl.op     = {op4, 4'h0};
        ctrl.r_dest = instr[11:8];
        imm         = imm_lui;
      end
      4'b0001, 4'b0010, 4'b0011: begin
        ctrl.op     = {op4, 4'h0};
        ctrl.r_dest = instr[11:8];
        imm         = (ZEXT_LOGIC != 0) ? imm_z8 : imm_s8;
      end
      4'b0101, 4'b0110, 4'b1001, 4'b1011, 4'b1101: begin
        ctrl.op     = {op4, 4'h0};
        ctrl.r_dest = instr[11:8];
        imm         = imm_s8;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered CR16 decode pipeline stage: valid/ready handshake with an
// optional skid entry, flush support and a wrap-around retire counter.
module decode_stage
  import cr16_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ZEXT_LOGIC = 1,
  parameter int SKID       = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        op,
  output logic [3:0]        r_dest,
  output logic [3:0]        r_src,
  output logic [DATA_W-1:0] immediate,
  output logic              r_or_i,
  output logic              is_branch,
  output logic              is_jump,
  output logic              is_mem,
  output logic              mem_write,
  output logic              illegal,
  output logic [CNT_W-1:0]  dec_count
);

  dec_ctrl_t         dec_ctrl;
  logic [DATA_W-1:0] dec_imm;

  dec_ctrl_t         main_ctrl;
  logic [DATA_W-1:0] main_imm;
  logic              main_valid;
  dec_ctrl_t         skid_ctrl;
  logic [DATA_W-1:0] skid_imm;
  logic              skid_valid;

  logic in_fire;
  logic out_fire;

  decode_comb #(
    .DATA_W     (DATA_W),
    .ZEXT_LOGIC (ZEXT_LOGIC)
  ) u_decode_comb (
    .instr (in_instr),
    .ctrl  (dec_ctrl),
    .imm   (dec_imm)
  );

  // With a skid entry the ready is purely registered; without one it looks through to out_ready
  assign in_ready = (SKID != 0) ? !skid_valid : (!main_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_valid && out_ready;

  // Main/skid entry management: skid only fills while main is stalled, and drains into main first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_imm   <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_imm   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || out_fire) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        main_imm   <= skid_imm;
        skid_valid <= in_fire;
        if (in_fire) begin
          skid_ctrl <= dec_ctrl;
          skid_imm  <= dec_imm;
        end
      end else begin
        main_valid <= in_fire;
        if (in_fire) begin
          main_ctrl <= dec_ctrl;
          main_imm  <= dec_imm;
        end
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= dec_ctrl;
      skid_imm   <= dec_imm;
    end
  end

  // Retire counter: every output handshake counts, even one coinciding with a flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_count <= '0;
    end else if (out_fire) begin
      dec_count <= dec_count + 1'b1;
    end
  end

  assign out_valid = main_valid;
  assign op        = main_ctrl.op;
  assign r_dest    = main_ctrl.r_dest;
  assign r_src     = main_ctrl.r_src;
  assign immediate = main_imm;
  assign r_or_i    = main_ctrl.r_or_i;
  assign is_branch = main_ctrl.is_branch;
  assign is_jump   = main_ctrl.is_jump;
  assign is_mem    = main_ctrl.is_mem;
  assign mem_write = main_ctrl.mem_write;
  assign illegal   = main_ctrl.illegal;

endmodule
